// File: rtl/i2c_arbiter.sv
// Round-robin arbiter sharing one i2c_master among NUM_REQ requesters.
// The master is held in reset while idle and released for exactly one transaction per grant.
module i2c_arbiter #(
    parameter int NUM_REQ = 2,
    parameter int TIMEOUT = 8192
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [NUM_REQ-1:0]      req_valid,
    input  logic [7*NUM_REQ-1:0]    req_addr,
    input  logic [32*NUM_REQ-1:0]   req_wdata,
    input  logic [4*NUM_REQ-1:0]    req_mask,
    input  logic [NUM_REQ-1:0]      req_write,
    output logic [NUM_REQ-1:0]      req_done,
    output logic                    req_err,
    output logic [31:0]             req_rdata,
    output logic                    m_reset,
    output logic [6:0]              m_device_addr,
    output logic [3:0]              m_mask,
    output logic [31:0]             m_data_in,
    output logic                    m_write,
    input  logic                    m_busy,
    input  logic [31:0]             m_data_out
);

    localparam int GW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

    localparam logic [1:0] IDLE      = 2'd0;
    localparam logic [1:0] WAIT_BUSY = 2'd1;
    localparam logic [1:0] WAIT_DONE = 2'd2;
    localparam logic [1:0] COMPLETE  = 2'd3;

    logic [1:0]               state;
    logic [GW-1:0]            ptr;
    logic [GW-1:0]            grant;
    logic [GW-1:0]            pick;
    logic                     found;
    logic [TW-1:0]            timer;
    logic                     tmo;
    logic [NUM_REQ-1:0]       grant_oh;
    logic [31:0]              rdata_masked;

    logic [NUM_REQ-1:0][6:0]  addr_v;
    logic [NUM_REQ-1:0][31:0] wdata_v;
    logic [NUM_REQ-1:0][3:0]  mask_v;

    assign addr_v  = req_addr;
    assign wdata_v = req_wdata;
    assign mask_v  = req_mask;

    function automatic logic [GW-1:0] wrap_idx(input logic [GW-1:0] base, input int k);
        int s;
        s = int'(base) + k;
        if (s >= NUM_REQ) s = s - NUM_REQ;
        return GW'(s);
    endfunction

    // Search starts just after the last grant, so the previous winner is considered last.
    always_comb begin
        pick  = '0;
        found = 1'b0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            if (!found && req_valid[wrap_idx(ptr, k)]) begin
                found = 1'b1;
                pick  = wrap_idx(ptr, k);
            end
        end
    end

    always_comb begin
        rdata_masked = '0;
        for (int b = 0; b < 4; b++)
            if (m_mask[b]) rdata_masked[8*b +: 8] = m_data_out[8*b +: 8];
    end

    assign grant_oh = NUM_REQ'(1) << grant;
    assign tmo      = (timer == TW'(TIMEOUT - 1));

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state         <= IDLE;
            ptr           <= GW'(NUM_REQ - 1);
            grant         <= '0;
            timer         <= '0;
            m_reset       <= 1'b1;
            m_device_addr <= '0;
            m_mask        <= '0;
            m_data_in     <= '0;
            m_write       <= 1'b0;
            req_done      <= '0;
            req_err       <= 1'b0;
            req_rdata     <= '0;
        end else begin
            req_done <= '0;
            req_err  <= 1'b0;
            case (state)
                IDLE: begin
                    m_reset <= 1'b1;
                    if (found) begin
                        m_device_addr <= addr_v[pick];
                        m_data_in     <= wdata_v[pick];
                        m_mask        <= mask_v[pick];
                        m_write       <= req_write[pick];
                        grant         <= pick;
                        ptr           <= pick;
                        timer         <= '0;
                        m_reset       <= 1'b0;
                        state         <= WAIT_BUSY;
                    end
                end
                // Master reports busy=0 while still in its reset state, so wait for it to start first.
                WAIT_BUSY: begin
                    timer <= timer + 1'b1;
                    if (tmo) begin
                        req_done  <= grant_oh;
                        req_err   <= 1'b1;
                        req_rdata <= '0;
                        m_reset   <= 1'b1;
                        state     <= COMPLETE;
                    end else if (m_busy) begin
                        state <= WAIT_DONE;
                    end
                end
                WAIT_DONE: begin
                    timer <= timer + 1'b1;
                    if (!m_busy) begin
                        req_done  <= grant_oh;
                        req_rdata <= m_write ? 32'd0 : rdata_masked;
                        m_reset   <= 1'b1;
                        state     <= COMPLETE;
                    end else if (tmo) begin
                        req_done  <= grant_oh;
                        req_err   <= 1'b1;
                        req_rdata <= '0;
                        m_reset   <= 1'b1;
                        state     <= COMPLETE;
                    end
                end
                // Done is visible this cycle; the following IDLE cycle keeps the master in reset.
                COMPLETE: begin
                    m_reset <= 1'b1;
                    state   <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_i2c_arbiter.sv
// Scoreboard bench for i2c_arbiter: stimulus queues expected grants/completions, a monitor checks them.
module tb_i2c_arbiter;

    localparam int NREQ = 2;
    localparam int TMO  = 32;

    logic                clk = 1'b0;
    logic                reset = 1'b0;
    logic [NREQ-1:0]     req_valid;
    logic [7*NREQ-1:0]   req_addr;
    logic [32*NREQ-1:0]  req_wdata;
    logic [4*NREQ-1:0]   req_mask;
    logic [NREQ-1:0]     req_write;
    logic [NREQ-1:0]     req_done;
    logic                req_err;
    logic [31:0]         req_rdata;
    logic                m_reset;
    logic [6:0]          m_device_addr;
    logic [3:0]          m_mask;
    logic [31:0]         m_data_in;
    logic                m_write;
    logic                m_busy = 1'b0;
    logic [31:0]         m_data_out;

    always #5 clk = ~clk;

    i2c_arbiter #(.NUM_REQ(NREQ), .TIMEOUT(TMO)) dut (
        .clk(clk), .reset(reset),
        .req_valid(req_valid), .req_addr(req_addr), .req_wdata(req_wdata),
        .req_mask(req_mask), .req_write(req_write),
        .req_done(req_done), .req_err(req_err), .req_rdata(req_rdata),
        .m_reset(m_reset), .m_device_addr(m_device_addr), .m_mask(m_mask),
        .m_data_in(m_data_in), .m_write(m_write),
        .m_busy(m_busy), .m_data_out(m_data_out)
    );

    // Master model: busy=0 in reset, then busy for 4 cycles, then END (busy=0) until reset.
    logic        no_device = 1'b0;
    logic [31:0] mdata = '0;
    int          mcnt = 0;
    assign m_data_out = mdata;

    always @(posedge clk) begin
        if (m_reset) begin
            m_busy <= 1'b0;
            mcnt   <= 0;
        end else begin
            mcnt   <= mcnt + 1;
            m_busy <= !no_device && (mcnt >= 1) && (mcnt < 5);
        end
    end

    typedef struct {
        logic [6:0]  addr;
        logic [3:0]  mask;
        logic [31:0] wdata;
        logic        write;
    } grant_t;

    typedef struct {
        int          idx;
        logic        err;
        logic [31:0] rdata;
        logic        chk_tmo;
    } done_t;

    grant_t gq[$];
    done_t  dq[$];

    int errors = 0;
    int checks = 0;
    int cyc = 0;
    int fall_cyc = 0;
    int done_seen = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic push_g(input logic [6:0] a, input logic [3:0] mk, input logic [31:0] wd, input logic w);
        grant_t g;
        g.addr = a; g.mask = mk; g.wdata = wd; g.write = w;
        gq.push_back(g);
    endtask

    task automatic push_d(input int i, input logic e, input logic [31:0] rd, input logic t);
        done_t d;
        d.idx = i; d.err = e; d.rdata = rd; d.chk_tmo = t;
        dq.push_back(d);
    endtask

    task automatic set_req(input int i, input logic [6:0] a, input logic [31:0] wd,
                           input logic [3:0] mk, input logic w);
        req_addr[7*i +: 7]   = a;
        req_wdata[32*i +: 32] = wd;
        req_mask[4*i +: 4]   = mk;
        req_write[i]         = w;
        req_valid[i]         = 1'b1;
    endtask

    task automatic wait_done(input int target, input int budget, input string name);
        for (int n = 0; n < budget && done_seen < target; n++) begin
            @(negedge clk);
            #1;
        end
        if (done_seen < target) begin
            checks++;
            errors++;
            $display("FAIL %s_wait: saw %0d completions required %0d", name, done_seen, target);
        end
    endtask

    // Monitor: grant contents on every m_reset fall, completion contents on every req_done.
    logic          prev_mr = 1'b1;
    logic          after_done = 1'b0;
    grant_t        mg;
    done_t         md;
    logic [NREQ-1:0] ev;

    always @(negedge clk) begin
        if (reset) begin
            if (after_done) chk("idle_after_done_mreset", 32'(m_reset), 32'd1);
            after_done = 1'b0;
            if (prev_mr && !m_reset) begin
                fall_cyc = cyc;
                if (gq.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL unexpected_grant: addr %h with no expected grant", m_device_addr);
                end else begin
                    mg = gq.pop_front();
                    chk("grant_addr",  32'(m_device_addr), 32'(mg.addr));
                    chk("grant_mask",  32'(m_mask),        32'(mg.mask));
                    chk("grant_wdata", m_data_in,          mg.wdata);
                    chk("grant_write", 32'(m_write),       32'(mg.write));
                end
            end
            if (req_done != '0) begin
                done_seen++;
                after_done = 1'b1;
                if (dq.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL unexpected_done: req_done %b with no expected completion", req_done);
                end else begin
                    md = dq.pop_front();
                    ev = '0;
                    ev[md.idx] = 1'b1;
                    chk("done_vec",     32'(req_done), 32'(ev));
                    chk("done_err",     32'(req_err),  32'(md.err));
                    chk("done_rdata",   req_rdata,     md.rdata);
                    chk("done_mreset",  32'(m_reset),  32'd1);
                    if (md.chk_tmo) chk("timeout_latency", 32'(cyc - fall_cyc), 32'(TMO));
                end
            end
        end
        prev_mr = m_reset;
    end

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_m_reset"},   32'(m_reset),       32'd1);
        chk({tag, "_m_addr"},    32'(m_device_addr), 32'd0);
        chk({tag, "_m_mask"},    32'(m_mask),        32'd0);
        chk({tag, "_m_data_in"}, m_data_in,          32'd0);
        chk({tag, "_m_write"},   32'(m_write),       32'd0);
        chk({tag, "_req_done"},  32'(req_done),      32'd0);
        chk({tag, "_req_err"},   32'(req_err),       32'd0);
        chk({tag, "_req_rdata"}, req_rdata,          32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        req_valid = '0; req_addr = '0; req_wdata = '0; req_mask = '0; req_write = '0;
        reset = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk_reset_vals("por");
        @(negedge clk) reset = 1'b1;
        @(negedge clk);

        // single write from requester 0
        push_g(7'h10, 4'b1100, 32'hAABB0000, 1'b1);
        push_d(0, 1'b0, 32'h0, 1'b0);
        set_req(0, 7'h10, 32'hAABB0000, 4'b1100, 1'b1);
        @(posedge clk); #1;
        chk("t1_release_latency", 32'(m_reset), 32'd0);
        wait_done(1, 100, "t1");
        req_valid[0] = 1'b0;

        // masked read from requester 1
        mdata = 32'h12345678;
        push_g(7'h22, 4'b0100, 32'hDEADBEEF, 1'b0);
        push_d(1, 1'b0, 32'h00340000, 1'b0);
        set_req(1, 7'h22, 32'hDEADBEEF, 4'b0100, 1'b0);
        wait_done(2, 100, "t2");
        req_valid[1] = 1'b0;

        // both requesters held from reset: grants alternate 0,1,0,1
        @(negedge clk) reset = 1'b0;
        @(negedge clk) reset = 1'b1;
        for (int r = 0; r < 2; r++) begin
            push_g(7'h10, 4'hF, 32'h11111111, 1'b1);
            push_g(7'h22, 4'hF, 32'h00000000, 1'b0);
            push_d(0, 1'b0, 32'h0, 1'b0);
            push_d(1, 1'b0, 32'h12345678, 1'b0);
        end
        set_req(0, 7'h10, 32'h11111111, 4'hF, 1'b1);
        set_req(1, 7'h22, 32'h00000000, 4'hF, 1'b0);
        wait_done(6, 200, "t3");
        req_valid = '0;

        // no device: abort exactly TMO cycles after release
        no_device = 1'b1;
        push_g(7'h33, 4'b0001, 32'h00000055, 1'b1);
        push_d(0, 1'b1, 32'h0, 1'b1);
        set_req(0, 7'h33, 32'h00000055, 4'b0001, 1'b1);
        wait_done(7, TMO + 20, "t4");
        req_valid[0] = 1'b0;
        no_device = 1'b0;
        mdata = 32'hCAFEF00D;
        push_g(7'h22, 4'b0011, 32'h0, 1'b0);
        push_d(1, 1'b0, 32'h0000F00D, 1'b0);
        set_req(1, 7'h22, 32'h0, 4'b0011, 1'b0);
        wait_done(8, 100, "t4b");
        req_valid[1] = 1'b0;

        // reset in WAIT_DONE: no completion, pending request regranted after release
        mdata = 32'hA5A5A5A5;
        push_g(7'h44, 4'hF, 32'h0, 1'b0);
        set_req(0, 7'h44, 32'h0, 4'hF, 1'b0);
        for (int n = 0; n < 50 && !m_busy; n++) @(negedge clk);
        if (!m_busy) begin
            checks++; errors++;
            $display("FAIL t5_busy_wait: busy %b required 1", m_busy);
        end
        @(posedge clk); #2;
        reset = 1'b0;
        #1;
        chk_reset_vals("t5_async");
        push_g(7'h44, 4'hF, 32'h0, 1'b0);
        push_d(0, 1'b0, 32'hA5A5A5A5, 1'b0);
        @(negedge clk);
        @(negedge clk) reset = 1'b1;
        wait_done(9, 100, "t5");
        req_valid[0] = 1'b0;

        // request raised during the done cycle waits out one IDLE cycle
        mdata = 32'h0;
        push_g(7'h10, 4'hF, 32'h01020304, 1'b1);
        push_d(0, 1'b0, 32'h0, 1'b0);
        set_req(0, 7'h10, 32'h01020304, 4'hF, 1'b1);
        wait_done(10, 100, "t6a");
        req_valid[0] = 1'b0;
        mdata = 32'h87654321;
        push_g(7'h22, 4'hF, 32'h0, 1'b0);
        push_d(1, 1'b0, 32'h87654321, 1'b0);
        set_req(1, 7'h22, 32'h0, 4'hF, 1'b0);
        @(negedge clk); #1;
        chk("t6_idle_cycle_mreset", 32'(m_reset), 32'd1);
        @(negedge clk); #1;
        chk("t6_grant_mreset", 32'(m_reset), 32'd0);
        wait_done(11, 100, "t6b");
        req_valid[1] = 1'b0;

        repeat (5) @(negedge clk);
        chk("grant_queue_left", 32'(gq.size()), 32'd0);
        chk("done_queue_left",  32'(dq.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
